// File: rtl/reg_slice_driver_if.sv
`default_nettype none
// ============================================================================
//  Module      : reg_slice_driver_if
//  Description : Valid/ready word stream feeding the register slice driver.
//                The master modport is the producer side; the slave modport is
//                the driver side that buffers and forwards the words.
//  Revision    : 1.0 - initial release
// ============================================================================
interface reg_slice_driver_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface
`default_nettype wire

// File: rtl/reg_slice_driver.sv
`default_nettype none
// ============================================================================
//  Module      : reg_slice_driver
//  Description : Buffers words from a valid/ready stream in a small FIFO and
//                issues each one as a single-cycle enable/data write pulse to
//                a downstream register, with GAP idle cycles between pulses.
//                Optional readback check of the register output is built in
//                when the macro REG_SLICE_DRV_CHECK_EN is defined; otherwise
//                err is tied low and outa is ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_slice_driver #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int GAP   = 0
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    reg_slice_driver_if.slave     s_in,
    output logic                  enable,
    output logic [WIDTH-1:0]      data,
    input  wire logic [WIDTH-1:0] outa,
    input  wire logic             clr,
    output logic                  busy,
    output logic [15:0]           wr_count,
    output logic                  err
);

    localparam int                c_ADDR_W    = $clog2(DEPTH);
    localparam logic [c_ADDR_W:0] c_DEPTH_CNT = (c_ADDR_W + 1)'(DEPTH);
    localparam logic [c_ADDR_W:0] c_ONE       = (c_ADDR_W + 1)'(1);
    localparam logic [7:0]        c_GAP_LOAD  = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [7:0]        r_gap_cnt;
    logic [7:0]        w_gap_cnt_nxt;

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [c_ADDR_W:0] r_wr_ptr;
    logic [c_ADDR_W:0] r_rd_ptr;
    logic [c_ADDR_W:0] w_count;
    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic              w_more;

    logic              r_enable;
    logic [WIDTH-1:0]  r_data;
    logic [15:0]       r_wr_count;

    // FIFO status; in_ready is held low throughout reset
    assign w_count       = r_wr_ptr - r_rd_ptr;
    assign w_empty       = (w_count == '0);
    assign w_full        = (w_count == c_DEPTH_CNT);
    assign s_in.in_ready = reset_n & ~w_full;
    assign w_push        = s_in.in_valid & s_in.in_ready;
    // ISSUE is only ever entered with a word at the head, so it always pops
    assign w_pop         = (r_state == ST_ISSUE);
    // A word remains after this pop, counting one arriving on the same edge
    assign w_more        = (w_count > c_ONE) | w_push;

    // FIFO storage write; contents need no reset since pointers gate validity
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_ADDR_W-1:0]] <= s_in.in_data;
        end
    end

    // FIFO pointers; extra MSB distinguishes full from empty
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ONE;
        end
    end

    // FSM state and gap counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_gap_cnt <= 8'd0;
        end else begin
            r_state   <= w_next_state;
            r_gap_cnt <= w_gap_cnt_nxt;
        end
    end

    // FSM next-state: issue one word, then optionally idle GAP cycles
    always_comb begin
        w_next_state  = r_state;
        w_gap_cnt_nxt = r_gap_cnt;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) w_next_state = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (GAP > 0) begin
                    w_next_state  = ST_WAIT;
                    w_gap_cnt_nxt = c_GAP_LOAD;
                end else if (w_more) begin
                    w_next_state = ST_ISSUE;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (r_gap_cnt == 8'd0) begin
                    w_next_state = w_empty ? ST_IDLE : ST_ISSUE;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt - 8'd1;
                end
            end
            default: begin
                w_next_state  = ST_IDLE;
                w_gap_cnt_nxt = 8'd0;
            end
        endcase
    end

    // Write pulse and data to the register; data holds between pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_enable <= 1'b0;
            r_data   <= '0;
        end else begin
            r_enable <= w_pop;
            if (w_pop) r_data <= r_mem[r_rd_ptr[c_ADDR_W-1:0]];
        end
    end

    // Write counter; clr wins over a same-cycle increment
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_count <= 16'd0;
        end else if (clr) begin
            r_wr_count <= 16'd0;
        end else if (w_pop) begin
            r_wr_count <= r_wr_count + 16'd1;
        end
    end

    assign enable   = r_enable;
    assign data     = r_data;
    assign wr_count = r_wr_count;
    assign busy     = (r_state != ST_IDLE) | ~w_empty;

`ifdef REG_SLICE_DRV_CHECK_EN
    logic             r_exp_vld;
    logic [WIDTH-1:0] r_exp_data;
    logic             r_err;

    // Second expected stage: lines up with the cycle outa shows the new word
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_exp_vld  <= 1'b0;
            r_exp_data <= '0;
        end else begin
            r_exp_vld <= r_enable;
            if (r_enable) r_exp_data <= r_data;
        end
    end

    // Sticky mismatch flag; clr wins over a same-cycle mismatch
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else if (clr) begin
            r_err <= 1'b0;
        end else if (r_exp_vld && (outa != r_exp_data)) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    logic w_unused_outa;
    assign w_unused_outa = ^outa;
    assign err           = 1'b0;
`endif

endmodule
`default_nettype wire
